fht_but_ctrl: RTL
=================

Name: fht_but_ctrl

Overview:
- Sequencer for the FHT butterfly (fht_but): walks all log2(N) radix-2 stages of an N-point in-place Hartley transform.
- Per butterfly it issues three read addresses (x0/x1/x2 operands), one twiddle ROM address (sin/cos) and two delayed write addresses for y0/y1.
- Sits between the ping-pong data RAM banks, the coefficient ROM and the butterfly, and reports busy/done to the top-level FHT controller.

Parameters:
- N_BIT, 10, log2 of transform size N; also the RAM address width.
- BUT_LAT, 3, butterfly pipeline latency in clocks, from operands-in to results-out.

Ports:
- iCLK  in  1  clock
- iRESET  in  1  asynchronous active-low reset
- iSTART  in  1  start request; sampled only in IDLE
- iHOLD  in  1  issue stall; freezes read issue only
- oBUSY  out  1  high from first RUN cycle through last FLUSH cycle
- oDONE  out  1  one-cycle pulse after the last stage drains
- oSTAGE  out  $clog2(N_BIT)  current stage index s
- oBANK  out  1  read bank select; write bank is ~oBANK
- oRD_EN  out  1  read strobe for all three operands
- oRD_ADDR_0/1/2  out  N_BIT each  operand x0/x1/x2 addresses
- oCOEF_ADDR  out  N_BIT-1  twiddle ROM address
- oWR_EN  out  1  write strobe
- oWR_ADDR_0/1  out  N_BIT each  y0/y1 write addresses

Behaviour:
- Reset: async on iRESET=0. FSM goes to IDLE; all outputs, counters and delay lines clear to 0 (oBANK=0). Reset mid-transform aborts with no oDONE.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN when iSTART=1; s=0, cnt=0, bank=0.
  - RUN issues one butterfly per cycle while iHOLD=0. After cnt = N/2-1 is issued -> FLUSH.
  - FLUSH lasts exactly BUT_LAT+1 cycles, then:
    - if s < N_BIT-1: s++, bank toggles, cnt=0, -> RUN;
    - else -> DONE.
  - DONE: one cycle, oDONE=1, -> IDLE.
  - iSTART while not in IDLE is ignored.
- Address generation per issue, with cnt in [0, N/2):
  - H = 2^s, L = 2^(s+1)
  - k = cnt mod H, g = (cnt >> s) << (s+1)
  - a0 = g+k; a1 = g+H+k; a2 = (k==0) ? g+H : g+L-k
  - coef = k << (N_BIT-1-s), truncated to N_BIT-1 bits
- Read/write outputs:
  - oRD_EN = (state==RUN) & ~iHOLD. Addresses are valid when oRD_EN=1 and 0 otherwise.
  - iHOLD in RUN: cnt frozen, oRD_EN=0. The write delay line keeps shifting; the butterfly is not stallable.
- Write timing:
  - a0/a1 and the issue strobe pass through a (BUT_LAT+1)-deep shift register (1 cycle RAM read + BUT_LAT).
  - A read issued at cycle t gives oWR_EN=1 with oWR_ADDR_0=a0, oWR_ADDR_1=a1 at cycle t+1+BUT_LAT.
  - FLUSH length guarantees the last write of a stage lands before the first read of the next stage.
- oSTAGE/oBANK are stable for the whole of RUN+FLUSH of a stage. After the final stage, the result resides in bank ~oBANK of the last stage.
- Total cycles without hold: N_BIT*(N/2+BUT_LAT+1), then the oDONE cycle.

Optional Feature:
- Macro: FHT_CTRL_BITREV_EN
- Defined: during stage 0 only, oRD_ADDR_0/1/2 are bit-reversed over N_BIT bits (input reordering on the fly). Write addresses are never reversed.
- Undefined: natural-order addresses in all stages; input data must already be bit-reversed in bank 0.

Test Plan:
- Basic sequencing, N_BIT=3, BUT_LAT=3, iSTART pulsed at edge 0:
  - oBUSY high cycles 1-24; oDONE high only at cycle 25.
  - oBANK = 0/1/0 for stages 0/1/2.
- Stage address sequences (a0,a1,a2;coef), N_BIT=3:
  - s0: (0,1,1;0) (2,3,3;0) (4,5,5;0) (6,7,7;0)
  - s1: (0,2,2;0) (1,3,3;2) (4,6,6;0) (5,7,7;2)
  - s2: (0,4,4;0) (1,5,7;1) (2,6,6;2) (3,7,5;3)
- Write delay: read of (1,5,7) at cycle 18 -> oWR_EN=1, oWR_ADDR_0=1, oWR_ADDR_1=5 at cycle 22.
  - Every stage shows 4 writes; no read of stage s+1 occurs before the last write of stage s.
- iHOLD high for 2 cycles during s1 cnt=2:
  - oRD_EN low those 2 cycles, sequence resumes at (4,6,6;0);
  - oDONE moves to cycle 27; in-flight writes are unaffected.
- iRESET low at cycle 10: all outputs 0 immediately (asynchronous). After release, IDLE; no oDONE until a new iSTART. iSTART pulsed at cycle 5 mid-run is ignored.
- With FHT_CTRL_BITREV_EN, N_BIT=3:
  - s0 a0 sequence = 0,2,1,3; a1 sequence = 4,6,5,7;
  - s1/s2 reads and all write addresses identical to the non-reversed case.

Source files
------------

// File: rtl/fht_but_ctrl.sv
// fht_but_ctrl: stage/butterfly sequencer for an in-place radix-2 FHT.
// Define FHT_CTRL_BITREV_EN to bit-reverse stage-0 read addresses (input reordering on the fly).
module fht_but_ctrl #(
  parameter int N_BIT   = 10,
  parameter int BUT_LAT = 3
) (
  input  logic                     iCLK,
  input  logic                     iRESET,
  input  logic                     iSTART,
  input  logic                     iHOLD,
  output logic                     oBUSY,
  output logic                     oDONE,
  output logic [$clog2(N_BIT)-1:0] oSTAGE,
  output logic                     oBANK,
  output logic                     oRD_EN,
  output logic [N_BIT-1:0]         oRD_ADDR_0,
  output logic [N_BIT-1:0]         oRD_ADDR_1,
  output logic [N_BIT-1:0]         oRD_ADDR_2,
  output logic [N_BIT-2:0]         oCOEF_ADDR,
  output logic                     oWR_EN,
  output logic [N_BIT-1:0]         oWR_ADDR_0,
  output logic [N_BIT-1:0]         oWR_ADDR_1
);
  localparam int SW = $clog2(N_BIT);
  localparam int D  = BUT_LAT + 1;
  localparam int FW = $clog2(BUT_LAT + 2);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
  localparam logic [SW-1:0] S_LAST = SW'(N_BIT - 1);
  localparam logic [FW-1:0] F_LAST = FW'(BUT_LAT);

  logic [1:0]       state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic             bank_q, bank_d;
  logic [N_BIT-2:0] cnt_q, cnt_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic [D-1:0]     wen_q;
  logic [N_BIT-1:0] wa0_q [D];
  logic [N_BIT-1:0] wa1_q [D];
  logic             issue;
  logic [N_BIT-1:0] h, mask, k, g, a0, a1, a2, r0, r1, r2;
  logic [N_BIT-2:0] cf;

  assign issue = (state_q == ST_RUN) && !iHOLD;
  assign h     = N_BIT'(1) << s_q;
  assign mask  = h - N_BIT'(1);
  assign k     = {1'b0, cnt_q} & mask;
  // (cnt >> s) << (s+1) is the group base with its low s+1 bits cleared
  assign g     = ({1'b0, cnt_q} & ~mask) << 1;
  assign a0    = g | k;
  assign a1    = a0 + h;
  assign a2    = (k == '0) ? g + h : g + (h << 1) - k;
  assign cf    = (N_BIT-1)'(k << (S_LAST - s_q));

`ifdef FHT_CTRL_BITREV_EN
  function automatic logic [N_BIT-1:0] rev(input logic [N_BIT-1:0] v);
    rev = '0;
    for (int i = 0; i < N_BIT; i++) rev[i] = v[N_BIT-1-i];
  endfunction
  logic first_stage;
  assign first_stage = (s_q == '0);
  assign r0 = first_stage ? rev(a0) : a0;
  assign r1 = first_stage ? rev(a1) : a1;
  assign r2 = first_stage ? rev(a2) : a2;
`else
  assign r0 = a0;
  assign r1 = a1;
  assign r2 = a2;
`endif

  assign oBUSY      = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign oDONE      = (state_q == ST_DONE);
  assign oSTAGE     = s_q;
  assign oBANK      = bank_q;
  assign oRD_EN     = issue;
  assign oRD_ADDR_0 = issue ? r0 : '0;
  assign oRD_ADDR_1 = issue ? r1 : '0;
  assign oRD_ADDR_2 = issue ? r2 : '0;
  assign oCOEF_ADDR = issue ? cf : '0;
  assign oWR_EN     = wen_q[D-1];
  assign oWR_ADDR_0 = wa0_q[D-1];
  assign oWR_ADDR_1 = wa1_q[D-1];

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    bank_d  = bank_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_IDLE: if (iSTART) begin
        state_d = ST_RUN;
        s_d     = '0;
        bank_d  = 1'b0;
        cnt_d   = '0;
      end
      ST_RUN: if (!iHOLD) begin
        cnt_d = cnt_q + (N_BIT-1)'(1);
        if (&cnt_q) begin
          state_d = ST_FLUSH;
          fcnt_d  = '0;
        end
      end
      ST_FLUSH: begin
        fcnt_d = fcnt_q + FW'(1);
        if (fcnt_q == F_LAST) begin
          state_d = (s_q == S_LAST) ? ST_DONE : ST_RUN;
          s_d     = (s_q == S_LAST) ? s_q : s_q + SW'(1);
          bank_d  = (s_q == S_LAST) ? bank_q : ~bank_q;
          cnt_d   = '0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // write side keeps shifting under iHOLD: the butterfly pipeline cannot stall
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      bank_q  <= 1'b0;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      wen_q   <= '0;
      for (int i = 0; i < D; i++) begin
        wa0_q[i] <= '0;
        wa1_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      bank_q   <= bank_d;
      cnt_q    <= cnt_d;
      fcnt_q   <= fcnt_d;
      wen_q[0] <= issue;
      wa0_q[0] <= issue ? a0 : '0;
      wa1_q[0] <= issue ? a1 : '0;
      for (int i = 1; i < D; i++) begin
        wen_q[i] <= wen_q[i-1];
        wa0_q[i] <= wa0_q[i-1];
        wa1_q[i] <= wa1_q[i-1];
      end
    end
  end
endmodule
